// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-stage port arbiter:
// FSM state encoding and default interface widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int AW_D   = 32;
    localparam int DW_D   = 32;
    localparam int TAGW_D = 4;
    localparam int REGW_D = 5;
    localparam int TMO_D  = 64;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker.
// Ports: valid0_i/valid1_i requests, rr_i favoured pipe, gnt_o one-hot grant.
module rr_arb2 (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       rr_i,
    output logic [1:0] gnt_o
);

    // A lone requester always wins; rr_i only breaks ties.
    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = valid0_i & (~valid1_i | ~rr_i);
        gnt_o[1] = valid1_i & (~valid0_i | rr_i);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-cache port between two issue pipes, round-robin,
// and returns a tagged completion to the RS/CDB logic.
// Ports: reqN_* pipe requests/ready, c_* cache port,
//        rsp_* one-cycle completion, err sticky cache-timeout flag.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW   = AW_D,
    parameter int DW   = DW_D,
    parameter int TAGW = TAGW_D,
    parameter int REGW = REGW_D,
    parameter int TMO  = TMO_D
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic            req0_we,
    input  logic [AW-1:0]   req0_addr,
    input  logic [DW-1:0]   req0_wdata,
    input  logic [TAGW-1:0] req0_tag,
    input  logic [REGW-1:0] req0_wreg,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic            req1_we,
    input  logic [AW-1:0]   req1_addr,
    input  logic [DW-1:0]   req1_wdata,
    input  logic [TAGW-1:0] req1_tag,
    input  logic [REGW-1:0] req1_wreg,
    output logic            req1_ready,
    output logic            c_en,
    output logic            c_we,
    output logic            c_rd,
    output logic [AW-1:0]   c_addr,
    output logic [DW-1:0]   c_wdata,
    input  logic [DW-1:0]   c_rdata,
    input  logic            c_ready,
    output logic            rsp_valid,
    output logic            rsp_src,
    output logic            rsp_is_load,
    output logic [TAGW-1:0] rsp_tag,
    output logic [REGW-1:0] rsp_wreg,
    output logic [DW-1:0]   rsp_rdata,
    output logic            err
);

    localparam int CW = $clog2(TMO + 1);

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic            src_q, src_d;
    logic            ld_q, ld_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [REGW-1:0] wreg_q, wreg_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [1:0]      gnt;
    logic [CW-1:0]   cnt_inc;

    rr_arb2 u_rr_arb2 (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .rr_i     (rr_q),
        .gnt_o    (gnt)
    );

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        src_d      = src_q;
        ld_d       = ld_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tag_d      = tag_q;
        wreg_d     = wreg_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        c_en       = 1'b0;
        c_we       = 1'b0;
        c_rd       = 1'b0;
        rsp_valid  = 1'b0;
        // Saturating so a stuck cache cannot wrap the count.
        cnt_inc    = (cnt_q == CW'(TMO)) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    req0_ready = gnt[0];
                    req1_ready = gnt[1];
                    src_d      = gnt[1];
                    ld_d       = gnt[1] ? ~req1_we   : ~req0_we;
                    addr_d     = gnt[1] ? req1_addr  : req0_addr;
                    wdata_d    = gnt[1] ? req1_wdata : req0_wdata;
                    tag_d      = gnt[1] ? req1_tag   : req0_tag;
                    wreg_d     = gnt[1] ? req1_wreg  : req0_wreg;
                    cnt_d      = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                c_en  = 1'b1;
                c_we  = ~ld_q;
                c_rd  = ld_q;
                cnt_d = cnt_inc;
                // Flag only; the access keeps waiting for the cache.
                if (cnt_inc == CW'(TMO)) begin
                    err_d = 1'b1;
                end
                if (c_ready) begin
                    rdata_d = ld_q ? c_rdata : '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rr_d      = ~src_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            src_q   <= 1'b0;
            ld_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tag_q   <= '0;
            wreg_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            ld_q    <= ld_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tag_q   <= tag_d;
            wreg_q  <= wreg_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign c_addr      = addr_q;
    assign c_wdata     = wdata_q;
    assign rsp_src     = src_q;
    assign rsp_is_load = ld_q;
    assign rsp_tag     = tag_q;
    assign rsp_wreg    = wreg_q;
    assign rsp_rdata   = rdata_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a completion scoreboard.
// Ports: none (top-level bench).
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic        req0_valid, req0_we, req0_ready;
    logic [31:0] req0_addr, req0_wdata;
    logic [3:0]  req0_tag;
    logic [4:0]  req0_wreg;
    logic        req1_valid, req1_we, req1_ready;
    logic [31:0] req1_addr, req1_wdata;
    logic [3:0]  req1_tag;
    logic [4:0]  req1_wreg;
    logic        c_en, c_we, c_rd, c_ready;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        rsp_valid, rsp_src, rsp_is_load;
    logic [3:0]  rsp_tag;
    logic [4:0]  rsp_wreg;
    logic [31:0] rsp_rdata;
    logic        err;

    typedef struct packed {
        logic        src;
        logic        ld;
        logic [3:0]  tag;
        logic [4:0]  wreg;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          rsp_cnt = 0;
    int          base;
    logic        gsrc;
    logic        prev_en = 1'b0;
    logic [31:0] prev_addr, prev_wdata;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .AW(32), .DW(32), .TAGW(4), .REGW(5), .TMO(64)
    ) dut (
        .CLK(CLK), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_tag(req0_tag), .req0_wreg(req0_wreg),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_tag(req1_tag), .req1_wreg(req1_wreg),
        .req1_ready(req1_ready),
        .c_en(c_en), .c_we(c_we), .c_rd(c_rd),
        .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src),
        .rsp_is_load(rsp_is_load), .rsp_tag(rsp_tag),
        .rsp_wreg(rsp_wreg), .rsp_rdata(rsp_rdata),
        .err(err)
    );

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_rsp(input int target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (rsp_cnt >= target) break;
            sample();
        end
        check("rsp_timeout", 64'(rsp_cnt >= target), 64'd1);
    endtask

    // Completion scoreboard and cache-port stability monitor.
    always @(negedge CLK) begin
        rsp_t e;
        if (rsp_valid) begin
            rsp_cnt++;
            check("rsp_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_fields",
                      {rsp_src, rsp_is_load, rsp_tag,
                       rsp_wreg, rsp_rdata}, e);
            end
        end
        if (c_en && prev_en) begin
            check("c_addr_stable", c_addr, prev_addr);
            check("c_wdata_stable", c_wdata, prev_wdata);
        end
        prev_en    = c_en;
        prev_addr  = c_addr;
        prev_wdata = c_wdata;
    end

    initial begin
        reset = 1'b1;
        {req0_valid, req0_we, req0_addr, req0_wdata} = '0;
        {req0_tag, req0_wreg} = '0;
        {req1_valid, req1_we, req1_addr, req1_wdata} = '0;
        {req1_tag, req1_wreg} = '0;
        c_ready = 1'b0;
        c_rdata = '0;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;
        sample();

        // Reset state
        check("rst_c_en", c_en, 0);
        check("rst_c_we", c_we, 0);
        check("rst_c_rd", c_rd, 0);
        check("rst_c_addr", c_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_load", rsp_is_load, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_err", err, 0);

        // Single load on pipe 0
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h40;
        req0_tag = 4'd3; req0_wreg = 5'd7;
        sb.push_back({1'b0, 1'b1, 4'd3, 5'd7, 32'hDEADBEEF});
        #1;
        check("t1_ready0", req0_ready, 1);
        check("t1_ready1", req1_ready, 0);
        @(posedge CLK);
        #1 req0_valid = 1'b0;
        sample();
        check("t1_c_en", c_en, 1);
        check("t1_c_rd", c_rd, 1);
        check("t1_c_we", c_we, 0);
        check("t1_c_addr", c_addr, 32'h40);
        check("t1_ready_busy", req0_ready, 0);
        @(posedge CLK);
        #1 c_ready = 1'b1; c_rdata = 32'hDEADBEEF;
        sample();
        check("t1_no_rsp_yet", rsp_valid, 0);
        @(posedge CLK);
        #1 c_ready = 1'b0;
        sample();
        check("t1_rsp_cycle", rsp_valid, 1);
        @(posedge CLK);
        #1;
        sample();
        check("t1_rsp_pulse", rsp_valid, 0);
        check("t1_idle_c_en", c_en, 0);

        // Both pipes storing, cache always ready
        @(posedge CLK);
        #1 reset = 1'b1;
        @(posedge CLK);
        #1 reset = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h100;
        req0_wdata = 32'hA0A0; req0_tag = 4'd1; req0_wreg = 5'd1;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h200;
        req1_wdata = 32'hB0B0; req1_tag = 4'd2; req1_wreg = 5'd2;
        c_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back({1'b0, 1'b0, 4'd1, 5'd1, 32'h0});
            sb.push_back({1'b1, 1'b0, 4'd2, 5'd2, 32'h0});
        end
        base = rsp_cnt;
        gsrc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req0_ready) gsrc = 1'b0;
            if (req1_ready) gsrc = 1'b1;
            sample();
            if (c_en) begin
                check("t2_c_we_busy", c_we, 1);
                check("t2_c_addr", c_addr,
                      gsrc ? 32'h200 : 32'h100);
            end else begin
                check("t2_c_we_idle", c_we, 0);
            end
            if (rsp_cnt >= base + 4) break;
            @(posedge CLK);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("t2_count", rsp_cnt - base, 4);

        // Pipe 1 alone while rr favours pipe 0
        c_rdata = 32'h12345678;
        req1_we = 1'b0; req1_addr = 32'h80;
        req1_tag = 4'd5; req1_wreg = 5'd9;
        @(posedge CLK);
        #1 req1_valid = 1'b1;
        sb.push_back({1'b1, 1'b1, 4'd5, 5'd9, 32'h12345678});
        #1;
        check("t3_ready1", req1_ready, 1);
        check("t3_ready0", req0_ready, 0);
        @(posedge CLK);
        #1 req1_valid = 1'b0;
        wait_rsp(base + 5, 10);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(posedge CLK);
        #1;
        check("t3_rr_back0", req0_ready, 1);
        check("t3_rr_not1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Cache timeout
        c_ready = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h300;
        req0_wdata = 32'h55; req0_tag = 4'd6; req0_wreg = 5'd10;
        sb.push_back({1'b0, 1'b0, 4'd6, 5'd10, 32'h0});
        @(posedge CLK);
        #1 req0_valid = 1'b0;
        repeat (63) @(posedge CLK);
        sample();
        check("t4_err_before", err, 0);
        check("t4_busy", c_en, 1);
        @(posedge CLK);
        sample();
        check("t4_err_at_tmo", err, 1);
        repeat (6) @(posedge CLK);
        sample();
        check("t4_err_sticky", err, 1);
        check("t4_still_wait", rsp_valid, 0);
        c_ready = 1'b1;
        @(posedge CLK);
        #1 c_ready = 1'b0;
        sample();
        check("t4_rsp_late", rsp_valid, 1);
        check("t4_err_kept", err, 1);

        // Reset while BUSY
        @(posedge CLK);
        #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h44;
        req0_tag = 4'd7; req0_wreg = 5'd3;
        @(posedge CLK);
        #1 req0_valid = 1'b0;
        sample();
        check("t5_busy", c_en, 1);
        @(posedge CLK);
        #1 reset = 1'b1;
        @(posedge CLK);
        #1 reset = 1'b0;
        base = rsp_cnt;
        sample();
        check("t5_c_en", c_en, 0);
        check("t5_c_rd", c_rd, 0);
        check("t5_c_addr", c_addr, 0);
        check("t5_rsp_tag", rsp_tag, 0);
        check("t5_rsp_wreg", rsp_wreg, 0);
        check("t5_err_clr", err, 0);
        repeat (4) sample();
        check("t5_no_rsp", rsp_cnt - base, 0);

        // Re-presented op completes after reset
        c_ready = 1'b1; c_rdata = 32'hCAFE;
        req0_valid = 1'b1;
        sb.push_back({1'b0, 1'b1, 4'd7, 5'd3, 32'hCAFE});
        @(posedge CLK);
        #1 req0_valid = 1'b0;
        wait_rsp(base + 1, 10);
        c_ready = 1'b0;
        repeat (2) sample();
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
